// File: rtl/urisc_core_p.sv
// urisc_core_p: subtract-and-branch CPU core with run/step/restart control,
// a wait-state tolerant req/ack memory port, a sticky halt state and a saturating instruction counter.
module urisc_core_p #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int CNT_W     = 16,
  parameter int RESET_PC  = 1,
  parameter int HALT_ADDR = 0,
  parameter bit BR_LEQ    = 1'b1
) (
  input  logic             clk_PH1,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             restart,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             halted,
  output logic [AW-1:0]    pc,
  output logic             flag_n,
  output logic             flag_z,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [3:0] {S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_EXE, S_WB, S_HALT} state_t;
  localparam logic [AW-1:0] L_RST  = AW'(RESET_PC);
  localparam logic [AW-1:0] L_HALT = AW'(HALT_ADDR);
  state_t           r_state;
  logic [AW-1:0]    r_pc, r_op_a, r_op_b, r_op_c, r_mem_addr;
  logic [DW-1:0]    r_va, r_vb, r_mem_wdata;
  logic             r_mem_req, r_mem_we, r_halted, r_flag_n, r_flag_z;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    w_rd, w_npc;
  logic [DW-1:0]    w_res;
  // operand words are address-sized: truncated or zero-extended
  assign w_rd  = AW'(mem_rdata);
  assign w_res = r_vb - r_va;
  assign w_npc = (r_flag_n | (BR_LEQ & r_flag_z)) ? r_op_c : r_pc + AW'(3);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = r_halted;
  assign pc        = r_pc;
  assign flag_n    = r_flag_n;
  assign flag_z    = r_flag_z;
  assign instr_cnt = r_cnt;
  always_ff @(posedge clk_PH1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= L_RST;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_c      <= '0;
      r_va        <= '0;
      r_vb        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_cnt       <= '0;
    end else if (restart) begin
      r_state   <= S_IDLE;
      r_pc      <= L_RST;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (run | step) begin
          if (r_pc == L_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state    <= S_FA;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        S_FA: if (mem_ack) begin
          r_op_a     <= w_rd;
          r_mem_addr <= r_pc + AW'(1);
          r_state    <= S_FB;
        end
        S_FB: if (mem_ack) begin
          r_op_b     <= w_rd;
          r_mem_addr <= r_pc + AW'(2);
          r_state    <= S_FC;
        end
        S_FC: if (mem_ack) begin
          r_op_c     <= w_rd;
          r_mem_addr <= r_op_a;
          r_state    <= S_RA;
        end
        S_RA: if (mem_ack) begin
          r_va       <= mem_rdata;
          r_mem_addr <= r_op_b;
          r_state    <= S_RB;
        end
        S_RB: if (mem_ack) begin
          r_vb      <= mem_rdata;
          r_mem_req <= 1'b0;
          r_state   <= S_EXE;
        end
        S_EXE: begin
          r_flag_n    <= w_res[DW-1];
          r_flag_z    <= (w_res == '0);
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_op_b;
          r_mem_wdata <= w_res;
          r_state     <= S_WB;
        end
        S_WB: if (mem_ack) begin
          r_pc     <= w_npc;
          r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          r_mem_we <= 1'b0;
          if (w_npc == L_HALT) begin
            r_state   <= S_HALT;
            r_mem_req <= 1'b0;
            r_halted  <= 1'b1;
          end else if (run) begin
            r_state    <= S_FA;
            r_mem_addr <= w_npc;
          end else begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_urisc_core_p.sv
// tb_urisc_core_p: scoreboard bench for urisc_core_p with a latency-programmable memory responder.
module tb_urisc_core_p;
  localparam bit BR = 1'b1;
  logic        clk_PH1 = 1'b0;
  logic        rst_n = 1'b0, run = 1'b0, step = 1'b0, restart = 1'b0;
  logic        mem_req, mem_we, busy, halted, flag_n, flag_z;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_addr, mem_wdata, pc;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] instr_cnt;
  logic [7:0]  mem [256];
  logic [15:0] exp_q[$], act_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [15:0] e, a;
  int          n_vec = 0, n_err = 0, lat = 0, wc = 0, unstable = 0, cyc = 0;
  logic [7:0]  a_addr, a_wd;
  logic        a_we;

  urisc_core_p #(.DW(8), .AW(8), .CNT_W(16), .RESET_PC(1), .HALT_ADDR(0), .BR_LEQ(BR)) dut (
    .clk_PH1(clk_PH1), .rst_n(rst_n), .run(run), .step(step), .restart(restart),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .halted(halted), .pc(pc),
    .flag_n(flag_n), .flag_z(flag_z), .instr_cnt(instr_cnt));

  always #5 clk_PH1 = ~clk_PH1;

  // memory responder: ack after lat wait cycles, request fields must hold until the ack edge
  always @(negedge clk_PH1) begin
    if (!mem_req) begin
      wc = 0;
      mem_ack = 1'b0;
    end else begin
      if (mem_ack) wc = 0;
      if (wc == 0) begin
        a_addr = mem_addr; a_we = mem_we; a_wd = mem_wdata;
      end else if (mem_addr !== a_addr || mem_we !== a_we || mem_wdata !== a_wd) unstable++;
      mem_ack = (wc == lat);
      wc++;
      mem_rdata = mem[mem_addr];
    end
  end

  always @(posedge clk_PH1)
    if (rst_n && mem_req && mem_we && mem_ack) begin
      mem[mem_addr] = mem_wdata;
      act_q.push_back({mem_addr, mem_wdata});
    end

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i[7:0]] = 8'h00;
  endtask

  task automatic put(input logic [7:0] at, input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] oc);
    mem[at] = oa; mem[at + 8'd1] = ob; mem[at + 8'd2] = oc;
  endtask

  task automatic operands(input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] va, input logic [7:0] vb);
    logic [7:0] r;
    mem[oa] = va; mem[ob] = vb;
    r = vb - va;
    exp_q.push_back({ob, r});
    exp_cnt++;
  endtask

  task automatic do_restart;
    @(negedge clk_PH1) restart = 1'b1;
    @(negedge clk_PH1) restart = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    for (int i = 0; i < 500 && busy; i++) begin
      c++;
      @(negedge clk_PH1);
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy still %b after 500 cycles, required 0", busy);
    end
  endtask

  task automatic step_one(output int c);
    @(negedge clk_PH1) step = 1'b1;
    @(negedge clk_PH1) step = 1'b0;
    wait_idle(c);
  endtask

  task automatic test_reset;
    int reqs;
    repeat (3) @(negedge clk_PH1);
    n_vec++; if ({mem_req, mem_we, busy, halted, flag_n, flag_z} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b required 000000", {mem_req, mem_we, busy, halted, flag_n, flag_z}); end
    n_vec++; if ({mem_addr, mem_wdata, instr_cnt} !== 32'h0) begin n_err++; $display("FAIL reset_regs: got %h required 0", {mem_addr, mem_wdata, instr_cnt}); end
    n_vec++; if (pc !== 8'd1) begin n_err++; $display("FAIL reset_pc: got %0d required 1", pc); end
    rst_n = 1'b1;
    reqs = 0;
    repeat (5) @(negedge clk_PH1) if (mem_req !== 1'b0) reqs++;
    n_vec++; if (reqs != 0) begin n_err++; $display("FAIL reset_idle_req: got %0d requests required 0", reqs); end
  endtask

  task automatic test_branch;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd20); operands(8'd10, 8'd11, 8'd5, 8'd3);
    step_one(cyc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL branch_write: got %h required %h", a, e); end
    end
    n_vec++; if (pc !== 8'd20) begin n_err++; $display("FAIL branch_pc: got %0d required 20", pc); end
    n_vec++; if ({flag_n, flag_z} !== 2'b10) begin n_err++; $display("FAIL branch_flags: got %b required 10", {flag_n, flag_z}); end
    n_vec++; if (cyc != 7) begin n_err++; $display("FAIL branch_cycles: got %0d required 7", cyc); end
    n_vec++; if (mem[11] !== 8'hFE) begin n_err++; $display("FAIL branch_mem: got %h required fe", mem[11]); end
    n_vec++; if (instr_cnt !== exp_cnt) begin n_err++; $display("FAIL branch_cnt: got %0d required %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_no_branch;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd20); operands(8'd10, 8'd11, 8'd4, 8'd9);
    step_one(cyc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL nobranch_write: got %h required %h", a, e); end
    end
    n_vec++; if (pc !== 8'd4) begin n_err++; $display("FAIL nobranch_pc: got %0d required 4", pc); end
    n_vec++; if ({flag_n, flag_z} !== 2'b00) begin n_err++; $display("FAIL nobranch_flags: got %b required 00", {flag_n, flag_z}); end
  endtask

  task automatic test_zero;
    logic [7:0] xp;
    xp = BR ? 8'd20 : 8'd4;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd20); operands(8'd10, 8'd11, 8'd7, 8'd7);
    step_one(cyc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL zero_write: got %h required %h", a, e); end
    end
    n_vec++; if ({flag_n, flag_z} !== 2'b01) begin n_err++; $display("FAIL zero_flags: got %b required 01", {flag_n, flag_z}); end
    n_vec++; if (pc !== xp) begin n_err++; $display("FAIL zero_pc: got %0d required %0d", pc, xp); end
  endtask

  task automatic test_wait_states;
    lat = 3; unstable = 0;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd20); operands(8'd10, 8'd11, 8'd5, 8'd3);
    step_one(cyc);
    lat = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL wait_write: got %h required %h", a, e); end
    end
    n_vec++; if (cyc != 25) begin n_err++; $display("FAIL wait_cycles: got %0d required 25", cyc); end
    n_vec++; if (pc !== 8'd20) begin n_err++; $display("FAIL wait_pc: got %0d required 20", pc); end
    n_vec++; if (unstable != 0) begin n_err++; $display("FAIL wait_stable: got %0d changes required 0", unstable); end
  endtask

  task automatic test_run_drop;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd4); operands(8'd10, 8'd11, 8'd2, 8'd9);
    put(8'd4, 8'd12, 8'd13, 8'd7);
    @(negedge clk_PH1) run = 1'b1;
    repeat (3) @(negedge clk_PH1);
    run = 1'b0;
    wait_idle(cyc);
    repeat (3) @(negedge clk_PH1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL rundrop_write: got %h required %h", a, e); end
    end
    n_vec++; if (act_q.size() != 0) begin n_err++; $display("FAIL rundrop_extra: got %0d extra writes required 0", act_q.size()); end
    n_vec++; if ({pc, busy} !== {8'd4, 1'b0}) begin n_err++; $display("FAIL rundrop_pc: got pc %0d busy %b required pc 4 busy 0", pc, busy); end
    n_vec++; if (instr_cnt !== exp_cnt) begin n_err++; $display("FAIL rundrop_cnt: got %0d required %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_step;
    operands(8'd12, 8'd13, 8'd1, 8'd6);
    step_one(cyc);
    repeat (2) @(negedge clk_PH1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL step_write: got %h required %h", a, e); end
    end
    n_vec++; if ({pc, busy} !== {8'd7, 1'b0}) begin n_err++; $display("FAIL step_pc: got pc %0d busy %b required pc 7 busy 0", pc, busy); end
    n_vec++; if (instr_cnt !== exp_cnt) begin n_err++; $display("FAIL step_cnt: got %0d required %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_restart_mid;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd4); mem[10] = 8'd1; mem[11] = 8'd2;
    @(negedge clk_PH1) run = 1'b1;
    repeat (2) @(negedge clk_PH1);
    restart = 1'b1; run = 1'b0;
    @(negedge clk_PH1) restart = 1'b0;
    n_vec++; if ({mem_req, busy, pc} !== {2'b00, 8'd1}) begin n_err++; $display("FAIL restart_mid: got req %b busy %b pc %0d required 0 0 1", mem_req, busy, pc); end
    repeat (3) @(negedge clk_PH1);
    n_vec++; if (act_q.size() != 0) begin n_err++; $display("FAIL restart_nowrite: got %0d writes required 0", act_q.size()); end
  endtask

  task automatic test_back_to_back;
    do_restart; clear_mem;
    put(8'd1, 8'd10, 8'd11, 8'd4); operands(8'd10, 8'd11, 8'd1, 8'd2);
    put(8'd4, 8'd12, 8'd13, 8'd7); operands(8'd12, 8'd13, 8'd3, 8'd4);
    put(8'd7, 8'd14, 8'd15, 8'd0); operands(8'd14, 8'd15, 8'd5, 8'd3);
    @(negedge clk_PH1) run = 1'b1;
    @(negedge clk_PH1);
    wait_idle(cyc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
      n_vec++; if (a !== e) begin n_err++; $display("FAIL b2b_write: got %h required %h", a, e); end
    end
    n_vec++; if (cyc != 21) begin n_err++; $display("FAIL b2b_cycles: got %0d required 21", cyc); end
    n_vec++; if ({halted, pc} !== {1'b1, 8'd0}) begin n_err++; $display("FAIL b2b_halt: got halted %b pc %0d required 1 0", halted, pc); end
    n_vec++; if (instr_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt: got %0d required %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_halt;
    int reqs;
    reqs = 0;
    @(negedge clk_PH1) step = 1'b1;
    @(negedge clk_PH1) step = 1'b0;
    repeat (5) @(negedge clk_PH1) if (mem_req !== 1'b0 || busy !== 1'b0) reqs++;
    n_vec++; if (reqs != 0) begin n_err++; $display("FAIL halt_ignore: got %0d active cycles required 0", reqs); end
    n_vec++; if ({halted, pc} !== {1'b1, 8'd0}) begin n_err++; $display("FAIL halt_sticky: got halted %b pc %0d required 1 0", halted, pc); end
    run = 1'b0;
    do_restart;
    n_vec++; if ({halted, busy, pc} !== {2'b00, 8'd1}) begin n_err++; $display("FAIL halt_restart: got halted %b busy %b pc %0d required 0 0 1", halted, busy, pc); end
    n_vec++; if ({flag_n, instr_cnt} !== {1'b1, exp_cnt}) begin n_err++; $display("FAIL halt_kept: got n %b cnt %0d required 1 %0d", flag_n, instr_cnt, exp_cnt); end
  endtask

  initial begin
    clear_mem;
    test_reset;
    test_branch;
    test_no_branch;
    test_zero;
    test_wait_states;
    test_run_drop;
    test_step;
    test_restart_mid;
    test_back_to_back;
    test_halt;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
